// File: rtl/spi_loader_pkg.sv
// Shared constants and types for the SPI boot loader: command codes,
// AHB-lite encodings, FSM state types and the internal bus request record.
package spi_loader_pkg;

  // Default SPI command opcodes (overridable via spi_loader parameters)
  localparam logic [7:0] DEF_CMD_WRITE  = 8'h02;
  localparam logic [7:0] DEF_CMD_READ   = 8'h03;
  localparam logic [7:0] DEF_CMD_STATUS = 8'h05;
  localparam logic [7:0] DEF_CMD_GO     = 8'hAB;

  // AHB-lite encodings used by the loader's master port
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

  // SPI protocol FSM
  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    DUMMY,
    RDATA,
    STAT,
    DRAIN
  } spi_state_e;

  // AHB single-transfer FSM
  typedef enum logic [1:0] {
    B_IDLE,
    B_ADDR,
    B_DATA
  } bus_state_e;

  // One-cycle request from the SPI side to the bus side
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI input, plus rise/fall
// pulses derived from the synchronized level and one extra delay flop.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stage_q, stage_d;
  logic                   prev_q, prev_d;

  // Shift the raw input down the chain; keep a delayed copy for edge detect
  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    prev_d = stage_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-detect registers
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge; blocking would collapse the chain into one flop.
    if (reset) begin
      stage_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      stage_q <= stage_d;
      prev_q  <= prev_d;
    end
  end

  assign dout = stage_q[SYNC_STAGES-1];
  assign rise = dout & ~prev_q;
  assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_loader.sv
// SPI mode-0 slave that turns host command streams into single-word AHB-lite
// transfers for loading/reading memory, and holds the core in reset until GO.
module spi_loader
  import spi_loader_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_WRITE   = DEF_CMD_WRITE,
  parameter logic [7:0] CMD_READ    = DEF_CMD_READ,
  parameter logic [7:0] CMD_STATUS  = DEF_CMD_STATUS,
  parameter logic [7:0] CMD_GO      = DEF_CMD_GO
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [31:0] spi_haddr,
  output logic        spi_hwrite,
  output logic [2:0]  spi_hsize,
  output logic [2:0]  spi_hburst,
  output logic        spi_hmastlock,
  output logic [3:0]  spi_hprot,
  output logic [1:0]  spi_htrans,
  output logic [31:0] spi_hwdata,
  input  logic [31:0] spi_hrdata,
  input  logic        spi_hready,
  input  logic        spi_hrest,
  output logic        core_run,
  output logic        loader_err
);

  // ---------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------
  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic unused_sync_bits;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .din(sck),
    .dout(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  // cs_n idles high, so its chain resets high to avoid a phantom frame edge
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .din(cs_n),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi),
    .dout(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Levels of sck/cs and mosi edges are not needed by the protocol logic
  assign unused_sync_bits = sck_s ^ cs_s ^ mosi_rise ^ mosi_fall;

  // ---------------------------------------------------------------------
  // SPI protocol FSM
  // ---------------------------------------------------------------------
  spi_state_e  state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shift_in_q, shift_in_d;
  logic [31:0] shift_out_q, shift_out_d;
  logic [31:0] addr_q, addr_d;
  logic        is_read_q, is_read_d;
  logic        miso_q, miso_d;
  logic        core_run_q, core_run_d;
  logic [31:0] prefetch_q, prefetch_d;
  logic        loader_err_q, loader_err_d;

  logic [31:0] word_in;
  logic [31:0] next_addr;
  bus_req_t    req;

  // Next-state, shift registers and bus requests for the SPI side
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    miso_d      = miso_q;
    core_run_d  = core_run_q;
    req         = '0;
    word_in     = {shift_in_q[30:0], mosi_s};
    next_addr   = addr_q + 32'd4;

    if (cs_rise) begin
      // End of frame from any state: drop partial words, release miso
      state_d   = IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d   = CMD;
            bit_cnt_d = '0;
          end
        end

        CMD: begin
          if (sck_rise) begin
            shift_in_d = word_in;
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              if (word_in[7:0] == CMD_WRITE) begin
                is_read_d = 1'b0;
                state_d   = ADDR;
              end else if (word_in[7:0] == CMD_READ) begin
                is_read_d = 1'b1;
                state_d   = ADDR;
              end else if (word_in[7:0] == CMD_STATUS) begin
                shift_out_d = {6'b0, loader_err_q, core_run_q, 24'b0};
                state_d     = STAT;
              end else if (word_in[7:0] == CMD_GO) begin
                core_run_d = 1'b1;
                state_d    = DRAIN;
              end else begin
                state_d = DRAIN;
              end
            end
          end
        end

        ADDR: begin
          if (sck_rise) begin
            shift_in_d = word_in;
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
              bit_cnt_d = '0;
              addr_d    = {word_in[31:2], 2'b00};
              if (is_read_q) begin
                // Prefetch the first word while the dummy byte is clocked
                state_d    = DUMMY;
                req.valid  = 1'b1;
                req.write  = 1'b0;
                req.addr   = {word_in[31:2], 2'b00};
              end else begin
                state_d = WDATA;
              end
            end
          end
        end

        WDATA: begin
          if (sck_rise) begin
            shift_in_d = word_in;
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
              bit_cnt_d = '0;
              req.valid = 1'b1;
              req.write = 1'b1;
              req.addr  = addr_q;
              req.wdata = word_in;
              addr_d    = next_addr;
            end
          end
        end

        DUMMY: begin
          if (sck_fall) begin
            miso_d = 1'b0;
          end
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d   = '0;
              state_d     = RDATA;
              shift_out_d = prefetch_q;
              req.valid   = 1'b1;
              req.write   = 1'b0;
              req.addr    = next_addr;
              addr_d      = next_addr;
            end
          end
        end

        RDATA: begin
          if (sck_fall) begin
            miso_d      = shift_out_q[31];
            shift_out_d = {shift_out_q[30:0], 1'b0};
          end
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd31) begin
              // Word fully sent: swap in the prefetched word, fetch the next
              bit_cnt_d   = '0;
              shift_out_d = prefetch_q;
              req.valid   = 1'b1;
              req.write   = 1'b0;
              req.addr    = next_addr;
              addr_d      = next_addr;
            end
          end
        end

        STAT: begin
          if (sck_fall) begin
            miso_d      = shift_out_q[31];
            shift_out_d = {shift_out_q[30:0], 1'b0};
          end
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              state_d   = DRAIN;
            end
          end
        end

        DRAIN: begin
          // Wait for cs_n to rise
        end
      endcase
    end
  end

  // SPI-side state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      miso_q      <= 1'b0;
      core_run_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      is_read_q   <= is_read_d;
      miso_q      <= miso_d;
      core_run_q  <= core_run_d;
    end
  end

  // ---------------------------------------------------------------------
  // AHB-lite single-transfer master
  // ---------------------------------------------------------------------
  bus_state_e  b_state_q, b_state_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;

  // Address/data phase sequencing, read capture and error tracking
  always_comb begin
    b_state_d    = b_state_q;
    htrans_d     = htrans_q;
    haddr_d      = haddr_q;
    hwrite_d     = hwrite_q;
    hwdata_d     = hwdata_q;
    prefetch_d   = prefetch_q;
    loader_err_d = loader_err_q;

    case (b_state_q)
      B_IDLE: begin
        if (req.valid) begin
          b_state_d = B_ADDR;
          htrans_d  = HTRANS_NONSEQ;
          haddr_d   = req.addr;
          hwrite_d  = req.write;
          if (req.write) begin
            hwdata_d = req.wdata;
          end
        end
      end

      B_ADDR: begin
        if (spi_hready) begin
          b_state_d = B_DATA;
          htrans_d  = HTRANS_IDLE;
        end
      end

      B_DATA: begin
        if (spi_hrest) begin
          loader_err_d = 1'b1;
        end
        if (spi_hready) begin
          if (!hwrite_q) begin
            prefetch_d = spi_hrdata;
          end
          b_state_d = B_IDLE;
        end
      end

      default: begin
        b_state_d = B_IDLE;
        htrans_d  = HTRANS_IDLE;
      end
    endcase

    // A request while a transfer is in flight is lost; flag it
    if (req.valid && (b_state_q != B_IDLE)) begin
      loader_err_d = 1'b1;
    end
  end

  // Bus-side state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_state_q    <= B_IDLE;
      htrans_q     <= HTRANS_IDLE;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      hwdata_q     <= '0;
      prefetch_q   <= '0;
      loader_err_q <= 1'b0;
    end else begin
      b_state_q    <= b_state_d;
      htrans_q     <= htrans_d;
      haddr_q      <= haddr_d;
      hwrite_q     <= hwrite_d;
      hwdata_q     <= hwdata_d;
      prefetch_q   <= prefetch_d;
      loader_err_q <= loader_err_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign miso          = miso_q;
  assign spi_haddr     = haddr_q;
  assign spi_hwrite    = hwrite_q;
  assign spi_htrans    = htrans_q;
  assign spi_hwdata    = hwdata_q;
  assign spi_hsize     = HSIZE_WORD;
  assign spi_hburst    = HBURST_SINGLE;
  assign spi_hmastlock = 1'b0;
  assign spi_hprot     = HPROT_DEFAULT;
  assign core_run      = core_run_q;
  assign loader_err    = loader_err_q;

endmodule
